bcd_count_ctrl: RTL

- Sequencing controller around the existing combinational bcd_incrementer_3digit. It owns the 3-digit BCD count register and generates step events from an internal prescaler or an external pulse.
- Applies clear/load/step with fixed priority and detects 999->000 wrap.
- Publishes changed values to the 12864 LCD writer through a coalescing req/ack handshake.

---
 rtl/bcd_ctrl_pkg.sv | 9 +
 rtl/bcd_count_ctrl_tick.sv | 18 +
 rtl/bcd_incrementer_3digit.sv | 17 +
 rtl/bcd_count_ctrl.sv | 67 ++++++
 4 files changed

// File: rtl/bcd_ctrl_pkg.sv
// bcd_ctrl_pkg: shared display FSM states, BCD constants and nibble validity check
package bcd_ctrl_pkg;
  typedef enum logic {IDLE, REQ} state_t;
  localparam logic [11:0] BCD_ZERO = 12'h000;
  localparam logic [11:0] BCD_MAX = 12'h999;
  function automatic logic bcd_valid(input logic [11:0] v);
    return v[11:8] <= 4'd9 && v[7:4] <= 4'd9 && v[3:0] <= 4'd9;
  endfunction
endpackage

// File: rtl/bcd_count_ctrl_tick.sv
// bcd_tick_gen: prescaler (clk, rst_n, run, clr -> tick) pulsing tick every TICK_DIV running cycles
module bcd_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = run && cnt_q == PW'(TICK_DIV - 1);
    cnt_d = (clr || tick) ? '0 : run ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/bcd_incrementer_3digit.sv
// bcd_incrementer_3digit: combinational 3-digit BCD +1 (en, bcd_in -> bcd_out), wraps 999 to 000
module bcd_incrementer_3digit (
  input  logic        en,
  input  logic [11:0] bcd_in,
  output logic [11:0] bcd_out
);
  logic [3:0] c;
  assign c[0] = en;
  for (genvar i = 0; i < 3; i++) begin : g_dig
    logic [3:0] dig;
    logic nine;
    assign dig = bcd_in[4*i +: 4];
    assign nine = dig == 4'd9;
    assign bcd_out[4*i +: 4] = c[i] ? (nine ? 4'd0 : dig + 4'd1) : dig;
    assign c[i+1] = c[i] && nine;
  end
endmodule

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: 3-digit BCD counter with clr/load/step priority, wrap/ovf flags and coalescing display req/ack
import bcd_ctrl_pkg::*;
module bcd_count_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        ext_step,
  input  logic        clr,
  input  logic        load_en,
  input  logic [11:0] load_val,
  output logic [11:0] bcd_value,
  output logic        wrap,
  output logic        ovf,
  output logic        load_err,
  output logic        disp_req,
  output logic [11:0] disp_data,
  input  logic        disp_ack
);
  state_t state_q, state_d;
  logic [11:0] value_q, value_d, data_q, data_d, inc_val;
  logic wrap_q, wrap_d, ovf_q, ovf_d, load_err_q, load_err_d, dirty_q, dirty_d;
  logic tick, load_ok, do_step, upd;
  bcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .tick(tick)
  );
  bcd_incrementer_3digit u_inc (.en(1'b1), .bcd_in(value_q), .bcd_out(inc_val));
  always_comb begin
    load_ok = load_en && bcd_valid(load_val);
    do_step = !clr && !load_en && (tick || ext_step);
    value_d = clr ? BCD_ZERO : load_ok ? load_val : do_step ? inc_val : value_q;
    upd = clr || load_ok || do_step;
    wrap_d = do_step && value_q == BCD_MAX;
    ovf_d = !clr && (ovf_q || wrap_d);
    load_err_d = !clr && load_en && !load_ok;
    // dirty is consumed only on the IDLE->REQ edge; an update on that same edge re-arms it
    dirty_d = upd || (dirty_q && state_q == REQ);
    data_d = (state_q == IDLE && dirty_q) ? value_q : data_q;
  end
  always_comb state_d = state_q == IDLE ? (dirty_q ? REQ : IDLE) : (disp_ack ? IDLE : REQ);
  always_comb disp_req = state_q == REQ;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      value_q <= BCD_ZERO;
      data_q <= BCD_ZERO;
      wrap_q <= 1'b0;
      ovf_q <= 1'b0;
      load_err_q <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      data_q <= data_d;
      wrap_q <= wrap_d;
      ovf_q <= ovf_d;
      load_err_q <= load_err_d;
      dirty_q <= dirty_d;
    end
  end
  assign bcd_value = value_q;
  assign disp_data = data_q;
  assign wrap = wrap_q;
  assign ovf = ovf_q;
  assign load_err = load_err_q;
endmodule
